// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: handshake, redirect/trap/call/ret inputs and PC/RAS status outputs.
// master is the PC generator, slave is the fetch/execute side that drives redirects and consumes pc.
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             fetch_ready;
  logic [XLEN-1:0]  pc;
  logic             pc_valid;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_target;
  logic             call_valid;
  logic [XLEN-1:0]  call_target;
  logic             ret_valid;
  logic             misaligned;
  logic [XLEN-1:0]  misaligned_addr;
  logic [CNT_W-1:0] ras_count;

  modport master (
    input  fetch_ready, redirect_valid, redirect_target, trap_valid, trap_target,
           call_valid, call_target, ret_valid,
    output pc, pc_valid, misaligned, misaligned_addr, ras_count
  );

  modport slave (
    output fetch_ready, redirect_valid, redirect_target, trap_valid, trap_target,
           call_valid, call_target, ret_valid,
    input  pc, pc_valid, misaligned, misaligned_addr, ras_count
  );
endinterface

// File: rtl/pc_gen.sv
// Ready/valid-gated program counter with trap/redirect priority, a circular return-address
// stack for call/return prediction, and a HALT state entered on a misaligned redirect.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              RAS_DEPTH    = 4
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.master  bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic             r_pc_valid;
  logic             r_misaligned, w_misaligned_nxt;
  logic [XLEN-1:0]  r_misaligned_addr, w_misaligned_addr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [PTR_W-1:0] r_top, w_top_nxt;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];

  logic             w_fire;
  logic [XLEN-1:0]  w_pc_inc;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  // Occupancy saturates at depth; a push into a full stack silently drops the oldest entry.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_FULL) ? c : c + CNT_ONE;
  endfunction

  assign w_fire   = r_pc_valid & bus.fetch_ready;
  assign w_pc_inc = r_pc + XLEN'(4);

  always_comb begin
    w_state_nxt           = r_state;
    w_pc_nxt              = r_pc;
    w_misaligned_nxt      = 1'b0;
    w_misaligned_addr_nxt = r_misaligned_addr;
    w_count_nxt           = r_count;
    w_top_nxt             = r_top;
    w_wr_en               = 1'b0;
    w_wr_idx              = r_top;

    if (bus.trap_valid) begin
      w_pc_nxt    = bus.trap_target;
      w_state_nxt = RUN;
      w_count_nxt = '0;
    end else if (r_state == RUN && bus.redirect_valid) begin
      if (bus.redirect_target[1:0] == 2'b00) begin
        w_pc_nxt = bus.redirect_target;
      end else begin
        w_misaligned_nxt      = 1'b1;
        w_misaligned_addr_nxt = bus.redirect_target;
        w_state_nxt           = HALT;
      end
    end else if (w_fire && bus.call_valid && bus.ret_valid) begin
      // Coroutine swap: replace the top return address rather than pop-then-push.
      w_pc_nxt = bus.call_target;
      w_wr_en  = 1'b1;
      if (r_count == '0) begin
        w_top_nxt   = r_top + PTR_ONE;
        w_wr_idx    = r_top + PTR_ONE;
        w_count_nxt = sat_inc(r_count);
      end
    end else if (w_fire && bus.call_valid) begin
      w_pc_nxt    = bus.call_target;
      w_wr_en     = 1'b1;
      w_top_nxt   = r_top + PTR_ONE;
      w_wr_idx    = r_top + PTR_ONE;
      w_count_nxt = sat_inc(r_count);
    end else if (w_fire && bus.ret_valid) begin
      if (r_count != '0) begin
        w_pc_nxt    = r_ras[r_top];
        w_top_nxt   = r_top - PTR_ONE;
        w_count_nxt = r_count - CNT_ONE;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end else if (w_fire) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= RUN;
      r_pc              <= RESET_VECTOR;
      r_pc_valid        <= 1'b0;
      r_misaligned      <= 1'b0;
      r_misaligned_addr <= '0;
      r_count           <= '0;
      r_top             <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_pc              <= w_pc_nxt;
      r_pc_valid        <= (w_state_nxt == RUN);
      r_misaligned      <= w_misaligned_nxt;
      r_misaligned_addr <= w_misaligned_addr_nxt;
      r_count           <= w_count_nxt;
      r_top             <= w_top_nxt;
    end
  end

  // Stack storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) r_ras[w_wr_idx] <= w_pc_inc;
  end

  assign bus.pc              = r_pc;
  assign bus.pc_valid        = r_pc_valid;
  assign bus.misaligned      = r_misaligned;
  assign bus.misaligned_addr = r_misaligned_addr;
  assign bus.ras_count       = r_count;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V fetch front end. It replaces the plain PC register with a ready/valid-gated PC:
- sequential advance;
- resolved-branch and trap redirects with fixed priority;
- a small return-address stack (RAS) that predicts call/return targets;
- a halt state entered on a misaligned redirect target.

It sits between the fetch stage (which consumes `pc`) and the execute/trap logic (which supplies redirects).

## Interface
- `XLEN`, 32, address width in bits
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset (must be 4-byte aligned)
- `RAS_DEPTH`, 4, number of RAS entries (power of two, ≥2)

- `clk` input 1 — single clock; all state updates on posedge
- `reset` input 1 — synchronous, active-high
- `fetch_ready` input 1 — fetch accepts current `pc` this cycle
- `pc` output XLEN — current fetch address
- `pc_valid` output 1 — `pc` is presentable to fetch
- `redirect_valid` input 1 — execute-stage resolved branch/jump redirect
- `redirect_target` input XLEN — redirect address
- `trap_valid` input 1 — trap/exception redirect
- `trap_target` input XLEN — trap handler address (mtvec)
- `call_valid` input 1 — pre-decode: instruction at `pc` is a call
- `call_target` input XLEN — predicted call target
- `ret_valid` input 1 — pre-decode: instruction at `pc` is a return
- `misaligned` output 1 — one-cycle pulse: a redirect target had `target[1:0] != 0`
- `misaligned_addr` output XLEN — offending target, held until next misaligned event
- `ras_count` output $clog2(RAS_DEPTH)+1 — current RAS occupancy

## Operation
- States: RUN, HALT. `pc_valid = (state == RUN)`.
- Handshake (`fire`) = `pc_valid & fetch_ready`. Call/ret/sequential updates happen only on `fire`. Trap and redirect act regardless of `fire`.
- Next-PC priority, highest first:
  1. `trap_valid`: `pc <= trap_target`, state ← RUN (also exits HALT), RAS cleared (count = 0). A trap target is never checked for misalignment.
  2. `redirect_valid` in RUN:
     - If `redirect_target[1:0] == 0`: `pc <= redirect_target`. RAS unchanged.
     - Otherwise: `pc` holds, `misaligned` pulses, `misaligned_addr <= redirect_target`, state ← HALT.
  3. `fire & call_valid & ret_valid` (coroutine): `pc <= call_target`.
     - If count > 0: top entry overwritten with `pc+4`, count unchanged.
     - If count = 0: plain push of `pc+4`.
  4. `fire & call_valid`: push `pc+4`, `pc <= call_target`.
  5. `fire & ret_valid`:
     - If count > 0: `pc <= top`, pop.
     - If count = 0: `pc <= pc+4`, no pop.
  6. `fire`: `pc <= pc+4`.
  7. Otherwise: hold.
- HALT ignores redirect, call, ret and `fetch_ready`. Only `trap_valid` or `reset` leaves HALT.
- RAS is a circular buffer with a top pointer.
  - Push when full overwrites the oldest entry; count saturates at `RAS_DEPTH`.
  - Pop after wrap returns entries in LIFO order; the overwritten oldest entry is lost.
- Arithmetic: `pc+4` is modulo 2^XLEN, so `FFFF_FFFC + 4 = 0000_0000`. No flag is raised on wrap.
- `call_target` is not alignment-checked; fetch reports misaligned predictions.

## Timing
- All outputs are registered. A redirect, trap, call or ret sampled at edge N makes the new `pc` visible after edge N. Latency is 1 cycle, with no bubble.
- `misaligned` is high for exactly the one cycle following the sampling edge.
- During a cycle with `reset` high, on the next edge:
  - `pc = RESET_VECTOR`, `pc_valid = 0`
  - `misaligned = 0`, `misaligned_addr = 0`, `ras_count = 0`, state = RUN
- While `reset` is held, `pc_valid` stays 0. It rises the cycle after the first edge with `reset` low.
- `reset` overrides every other input, including `trap_valid`, and aborts HALT immediately.
- Trap and redirect in the same cycle: the trap wins and the redirect is dropped.
- Redirect with `fire & call_valid`: the redirect wins and the RAS is not pushed.

## Test plan
- Reset with `RESET_VECTOR = 0x100`, `fetch_ready = 1` for 3 cycles → `pc_valid` rises the cycle after reset drops; `pc` = 0x100, 0x104, 0x108, 0x10C. Then hold `fetch_ready = 0` for 2 cycles → `pc` is held.
- Call/return nesting with `RAS_DEPTH = 4`:
  - At `pc = 0x200`, call to 0x400; at 0x400, call to 0x800.
  - ret → `pc = 0x404`; ret → `pc = 0x204`; `ras_count` goes 1, 2, 1, 0.
  - A third ret → `pc = pc+4`, count stays 0.
- RAS overflow: 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_count = 4`. 5 rets → 0x54, 0x44, 0x34, 0x24, then sequential.
- Misaligned redirect to 0x302 → `misaligned` pulses 1 cycle, `misaligned_addr = 0x302`, `pc_valid = 0`, `pc` holds. Further redirects and fetches are ignored. Then `trap_valid` with target 0x80 → `pc = 0x80`, `pc_valid = 1`, `ras_count = 0`.
- Simultaneous events in one cycle:
  - Trap 0x80 + redirect 0x500 + call → `pc = 0x80`.
  - Next cycle, redirect 0x500 + `fire & call_valid` → `pc = 0x500`, `ras_count` unchanged.
- Wrap and coroutine:
  - From `pc = 0xFFFF_FFFC`, `fire` → `pc = 0`.
  - With `ras_count = 1` and top entry 0x44, assert `call_valid & ret_valid` at `pc = 0x90`, target 0xA00 → `pc = 0xA00`, top = 0x94, count = 1.
  - A mid-sequence `reset` → all outputs at their reset values the next cycle.
